// File: rtl/alarm_24hr.sv
// 24-hour alarm unit: programmable HH:MM alarm compared against counter_24hr BCD digits,
// with stop, snooze, no-response timeout and a square-wave buzzer while ringing.
module alarm_24hr #(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_MIN   = 1,
  parameter int unsigned BUZZ_DIV   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] hours_tens_i,
  input  logic [3:0] hours_ones_i,
  input  logic [3:0] minutes_tens_i,
  input  logic [3:0] minutes_ones_i,
  input  logic       arm_sw_i,
  input  logic       btn_hour_i,
  input  logic       btn_min_i,
  input  logic       btn_stop_i,
  input  logic       btn_snooze_i,
  output logic [3:0] al_hours_tens_o,
  output logic [3:0] al_hours_ones_o,
  output logic [3:0] al_min_tens_o,
  output logic [3:0] al_min_ones_o,
  output logic       armed_o,
  output logic       ringing_o,
  output logic       buzzer_o
);

  localparam int DIV_W = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       alHoursTens_q, alHoursTens_d;
  logic [3:0]       alHoursOnes_q, alHoursOnes_d;
  logic [3:0]       alMinTens_q, alMinTens_d;
  logic [3:0]       alMinOnes_q, alMinOnes_d;
  logic [3:0]       ringCnt_q, ringCnt_d;
  logic [3:0]       snzCnt_q, snzCnt_d;
  logic [3:0]       minOnes_q;
  logic             match_q;
  logic             started_q;
  logic             armed_q;
  logic             ringing_q;
  logic             buzz_q;
  logic [DIV_W-1:0] div_q;

  logic match;
  logic matchRise;
  logic tick;

  assign match = (hours_tens_i == alHoursTens_q) && (hours_ones_i == alHoursOnes_q) &&
                 (minutes_tens_i == alMinTens_q) && (minutes_ones_i == alMinOnes_q);

  // History registers hold garbage-free zeros after reset, so events wait one cycle.
  assign matchRise = started_q && match && !match_q;
  assign tick      = started_q && (minutes_ones_i != minOnes_q);

  always_comb begin
    alHoursTens_d = alHoursTens_q;
    alHoursOnes_d = alHoursOnes_q;
    alMinTens_d   = alMinTens_q;
    alMinOnes_d   = alMinOnes_q;
    if (state_q != RINGING) begin
      if (btn_hour_i) begin
        if (alHoursTens_q == 4'd2 && alHoursOnes_q == 4'd3) begin
          alHoursTens_d = 4'd0;
          alHoursOnes_d = 4'd0;
        end else if (alHoursOnes_q == 4'd9) begin
          alHoursTens_d = alHoursTens_q + 4'd1;
          alHoursOnes_d = 4'd0;
        end else begin
          alHoursOnes_d = alHoursOnes_q + 4'd1;
        end
      end
      if (btn_min_i) begin
        if (alMinOnes_q == 4'd9) begin
          alMinOnes_d = 4'd0;
          alMinTens_d = (alMinTens_q == 4'd5) ? 4'd0 : alMinTens_q + 4'd1;
        end else begin
          alMinOnes_d = alMinOnes_q + 4'd1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ringCnt_d = ringCnt_q;
    snzCnt_d  = snzCnt_q;
    if (!arm_sw_i) begin
      state_d   = DISARMED;
      ringCnt_d = 4'd0;
      snzCnt_d  = 4'd0;
    end else begin
      case (state_q)
        DISARMED: state_d = ARMED;
        ARMED: begin
          if (matchRise) begin
            state_d   = RINGING;
            ringCnt_d = 4'(RING_MIN);
          end
        end
        RINGING: begin
          if (btn_stop_i) begin
            state_d   = ARMED;
            ringCnt_d = 4'd0;
          end else if (btn_snooze_i) begin
            state_d   = SNOOZE;
            ringCnt_d = 4'd0;
            snzCnt_d  = 4'(SNOOZE_MIN);
          end else if (tick) begin
            if (ringCnt_q == 4'd1) begin
              state_d   = ARMED;
              ringCnt_d = 4'd0;
            end else begin
              ringCnt_d = ringCnt_q - 4'd1;
            end
          end
        end
        SNOOZE: begin
          if (btn_stop_i) begin
            state_d  = ARMED;
            snzCnt_d = 4'd0;
          end else if (tick) begin
            if (snzCnt_q == 4'd1) begin
              state_d   = RINGING;
              snzCnt_d  = 4'd0;
              ringCnt_d = 4'(RING_MIN);
            end else begin
              snzCnt_d = snzCnt_q - 4'd1;
            end
          end
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with the state change.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= DISARMED;
      alHoursTens_q <= 4'd0;
      alHoursOnes_q <= 4'd0;
      alMinTens_q   <= 4'd0;
      alMinOnes_q   <= 4'd0;
      ringCnt_q     <= 4'd0;
      snzCnt_q      <= 4'd0;
      minOnes_q     <= 4'd0;
      match_q       <= 1'b0;
      started_q     <= 1'b0;
      armed_q       <= 1'b0;
      ringing_q     <= 1'b0;
      buzz_q        <= 1'b0;
      div_q         <= '0;
    end else begin
      state_q       <= state_d;
      alHoursTens_q <= alHoursTens_d;
      alHoursOnes_q <= alHoursOnes_d;
      alMinTens_q   <= alMinTens_d;
      alMinOnes_q   <= alMinOnes_d;
      ringCnt_q     <= ringCnt_d;
      snzCnt_q      <= snzCnt_d;
      minOnes_q     <= minutes_ones_i;
      match_q       <= match;
      started_q     <= 1'b1;
      armed_q       <= (state_d != DISARMED);
      ringing_q     <= (state_d == RINGING);
      if (state_d == RINGING && state_q != RINGING) begin
        buzz_q <= 1'b1;
        div_q  <= '0;
      end else if (state_d == RINGING) begin
        if (div_q == DIV_W'(BUZZ_DIV - 1)) begin
          div_q  <= '0;
          buzz_q <= ~buzz_q;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end else begin
        buzz_q <= 1'b0;
        div_q  <= '0;
      end
    end
  end

  assign al_hours_tens_o = alHoursTens_q;
  assign al_hours_ones_o = alHoursOnes_q;
  assign al_min_tens_o   = alMinTens_q;
  assign al_min_ones_o   = alMinOnes_q;
  assign armed_o         = armed_q;
  assign ringing_o       = ringing_q;
  assign buzzer_o        = buzz_q;

endmodule
